// File: rtl/mult_unit_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_unit_seq_pkg
// Description : Shared ALU control codes used by the ALU control decoder and
//               the EX-stage execution units, plus small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_unit_seq_pkg;

  // ALU control codes produced by the ALU control decoder
  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_MULT = 4'd8
  } alu_ctrl_e;

  localparam logic [3:0] c_ALU_AND  = 4'd0;
  localparam logic [3:0] c_ALU_OR   = 4'd1;
  localparam logic [3:0] c_ALU_ADD  = 4'd2;
  localparam logic [3:0] c_ALU_SLL  = 4'd3;
  localparam logic [3:0] c_ALU_SRL  = 4'd4;
  localparam logic [3:0] c_ALU_SUB  = 4'd6;
  localparam logic [3:0] c_ALU_SLT  = 4'd7;
  localparam logic [3:0] c_ALU_MULT = 4'd8;

  // True when the code selects a multi-cycle unit (the pipeline must stall)
  function automatic logic is_multicycle(input logic [3:0] code);
    return (code == c_ALU_MULT);
  endfunction

endpackage : mult_unit_seq_pkg
`default_nettype wire

// File: rtl/mult_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : mult_unit_seq
// Description : Iterative shift-add multiplier for the EX stage. Stalls the
//               pipeline for DATA_W+1 cycles and returns the low DATA_W bits
//               of op_a*op_b with a one-cycle result_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_unit_seq
  import mult_unit_seq_pkg::*;
#(
  parameter int         DATA_W        = 32,
  parameter int         CNT_W         = 6,
  parameter logic [3:0] ALU_CTRL_MULT = c_ALU_MULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        alu_control,
  input  logic              ex_valid,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  // The counter must be able to hold DATA_W-1
  if (2**CNT_W <= DATA_W) begin : g_cnt_w_check
    $error("mult_unit_seq: CNT_W too small for DATA_W");
  end

  // Unit-local state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DATA_W - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] r_result;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_acc_next;
  logic              w_start;
  logic              w_last;
  logic              w_stall;
  logic              w_result_valid;

  // Start only for a real, unsquashed MULT instruction
  always_comb begin
    w_start = ex_valid & (alu_control == ALU_CTRL_MULT) & ~flush;
  end

  // Next accumulator value and final-iteration detect
  always_comb begin
    w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_last     = (r_cnt == c_CNT_LAST);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, stall and result_valid decode
  always_comb begin
    w_state_next   = r_state;
    w_stall        = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_start;
        if (w_start) begin
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A flush releases the pipeline in the same cycle and abandons the product
        if (flush) begin
          w_state_next = ST_IDLE;
        end else begin
          w_stall = 1'b1;
          if (w_last) begin
            w_state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The instruction leaves EX this cycle, so a new start is not taken here
        w_result_valid = 1'b1;
        w_state_next   = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (!rst_n) begin
      w_stall        = 1'b0;
      w_result_valid = 1'b0;
    end
  end

  // Shift-add datapath: one multiplier bit per cycle, result latched on the last step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        ST_BUSY: begin
          if (!flush) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= w_acc_next;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign stall        = w_stall;
  assign result       = r_result;
  assign result_valid = w_result_valid;

endmodule : mult_unit_seq
`default_nettype wire

// File: tb/tb_mult_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_unit_seq
// Description : Self-checking bench for mult_unit_seq with directed cases and
//               randomized operands checked against a plain product model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_unit_seq;

  localparam int c_DATA_W = 32;
  localparam int c_LAT    = c_DATA_W + 1;

  logic                clk;
  logic                rst_n;
  logic [3:0]          alu_control;
  logic                ex_valid;
  logic                flush;
  logic [c_DATA_W-1:0] op_a;
  logic [c_DATA_W-1:0] op_b;
  logic                stall;
  logic [c_DATA_W-1:0] result;
  logic                result_valid;

  int                  n_tests;
  int                  n_fail;
  logic [c_DATA_W-1:0] last_res;

  mult_unit_seq #(
    .DATA_W        (c_DATA_W),
    .CNT_W         (6),
    .ALU_CTRL_MULT (4'd8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_control  (alu_control),
    .ex_valid     (ex_valid),
    .flush        (flush),
    .op_a         (op_a),
    .op_b         (op_b),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Issue one MULT and follow it to its result pulse; returns in the DONE cycle
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    logic [31:0] res;
    int          n_stall;
    int          lat;
    bit          got;
    prod    = {32'd0, a} * {32'd0, b};
    res     = '0;
    n_stall = 0;
    lat     = -1;
    got     = 1'b0;
    @(negedge clk);
    ex_valid    = 1'b1;
    alu_control = 4'd8;
    op_a        = a;
    op_b        = b;
    flush       = 1'b0;
    for (int c = 0; c < c_LAT + 6; c++) begin
      #1;
      if (stall) n_stall++;
      if (result_valid) begin
        got = 1'b1;
        lat = c;
        res = result;
        break;
      end
      @(negedge clk);
    end
    check("valid_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(c_LAT));
    check("stall_cycles", 32'(n_stall), 32'(c_LAT));
    check("product", res, prod[31:0]);
    last_res = prod[31:0];
  endtask

  // Idle cycles with no instruction: no stall, no pulse, result held
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      flush    = 1'b0;
      #1;
      check("idle_stall", 32'(stall), 32'd0);
      check("idle_valid", 32'(result_valid), 32'd0);
      check("held_result", result, last_res);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  codes [2];
    n_tests     = 0;
    n_fail      = 0;
    last_res    = '0;
    codes[0]    = 4'd2;
    codes[1]    = 4'd6;

    // Reset held for 3 cycles while a start is presented
    rst_n       = 1'b0;
    ex_valid    = 1'b1;
    alu_control = 4'd8;
    flush       = 1'b0;
    op_a        = 32'd5;
    op_b        = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_valid", 32'(result_valid), 32'd0);
      check("rst_result", result, 32'd0);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    ex_valid = 1'b0;
    idle(2);

    // Basic and wrap cases
    do_mult(32'd7, 32'd6);
    idle(2);
    do_mult(32'hFFFF_FFFF, 32'd2);
    idle(1);
    do_mult(32'h8000_0000, 32'd2);
    idle(1);

    // Flush in BUSY cycle 10
    @(negedge clk);
    ex_valid    = 1'b1;
    alu_control = 4'd8;
    op_a        = 32'd1234;
    op_b        = 32'd99;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'd0);
    @(negedge clk);
    flush    = 1'b0;
    ex_valid = 1'b0;
    #1;
    check("post_flush_stall", 32'(stall), 32'd0);
    check("post_flush_valid", 32'(result_valid), 32'd0);
    check("post_flush_result", result, last_res);
    idle(c_LAT + 2);
    do_mult(32'd11, 32'd13);
    idle(1);

    // Non-MULT codes and MULT without ex_valid never stall
    foreach (codes[k]) begin
      @(negedge clk);
      ex_valid    = 1'b1;
      alu_control = codes[k];
      for (int i = 0; i < 4; i++) begin
        #1;
        check("nonmult_stall", 32'(stall), 32'd0);
        check("nonmult_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
      end
    end
    ex_valid    = 1'b0;
    alu_control = 4'd8;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("novalid_stall", 32'(stall), 32'd0);
      @(negedge clk);
    end
    check("novalid_result", result, last_res);

    // Back-to-back with exactly one start cycle between pulses
    do_mult(32'd3, 32'd5);
    do_mult(32'd0, 32'd12345);
    idle(1);

    // Reset in the middle of an operation
    @(negedge clk);
    ex_valid    = 1'b1;
    alu_control = 4'd8;
    op_a        = 32'd77;
    op_b        = 32'd88;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    ex_valid = 1'b0;
    last_res = '0;
    idle(c_LAT + 1);

    // Random regression against the plain product
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 3) a = '0;
      if (i == 7) b = 32'hFFFF_FFFF;
      if (i == 9) b = '0;
      do_mult(a, b);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mult_unit_seq
`default_nettype wire
